// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and grant identifiers.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGntCpu,
    StGntDbg,
    StDone
  } arb_state_e;

  localparam logic GrantCpu = 1'b0;
  localparam logic GrantDbg = 1'b1;

  // Width of the per-access timeout counter; covers TIMEOUT up to 255.
  localparam int unsigned TmoW = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a debug/loader master.
// One access at a time: IDLE -> GNT_x -> DONE -> IDLE, round-robin on ties,
// per-access timeout abort, and a saturating CPU stall-cycle counter.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // CPU requester
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_err_o,
  output logic              cpu_stall_o,
  // Debug/loader requester
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              dbg_err_o,
  // Memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  // Statistics
  output logic [CNT_W-1:0]  wait_cnt_o
);

  import dmem_arb_pkg::*;

  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_err_q, cpu_err_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              dbg_err_q, dbg_err_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic in_gnt;
  logic gnt_is_dbg;

  assign in_gnt     = (state_q == StGntCpu) || (state_q == StGntDbg);
  assign gnt_is_dbg = (state_q == StGntDbg);

  // Arbitration, handshake sequencing and timeout abort.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    dbg_ack_d    = 1'b0;
    dbg_err_d    = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;

    case (state_q)
      StIdle: begin
        // CPU wins alone, or on a tie when DBG was served last.
        if (cpu_req_i && (!dbg_req_i || (last_grant_q == GrantDbg))) begin
          state_d      = StGntCpu;
          last_grant_d = GrantCpu;
          cmd_we_d     = cpu_we_i;
          cmd_addr_d   = cpu_addr_i;
          cmd_wdata_d  = cpu_wdata_i;
          tmo_cnt_d    = '0;
        end else if (dbg_req_i) begin
          state_d      = StGntDbg;
          last_grant_d = GrantDbg;
          cmd_we_d     = dbg_we_i;
          cmd_addr_d   = dbg_addr_i;
          cmd_wdata_d  = dbg_wdata_i;
          tmo_cnt_d    = '0;
        end
      end
      StGntCpu, StGntDbg: begin
        if (mem_ack_i) begin
          state_d = StDone;
          if (gnt_is_dbg) begin
            dbg_ack_d = 1'b1;
            if (!cmd_we_q) dbg_rdata_d = mem_rdata_i;
          end else begin
            cpu_ack_d = 1'b1;
            if (!cmd_we_q) cpu_rdata_d = mem_rdata_i;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          // Abort: ack with error, read data left untouched.
          state_d = StDone;
          if (gnt_is_dbg) begin
            dbg_ack_d = 1'b1;
            dbg_err_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
            cpu_err_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Saturating count of CPU stall cycles.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (cpu_stall_o && !(&wait_cnt_q)) begin
      wait_cnt_d = wait_cnt_q + CntOne;
    end
  end

  // State and datapath registers; reset aborts any access without an ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      last_grant_q <= GrantDbg;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      dbg_err_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_err_q    <= cpu_err_d;
      dbg_ack_q    <= dbg_ack_d;
      dbg_err_q    <= dbg_err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    mem_req_o   = in_gnt;
    mem_we_o    = cmd_we_q;
    mem_addr_o  = cmd_addr_q;
    mem_wdata_o = cmd_wdata_q;
    cpu_rdata_o = cpu_rdata_q;
    cpu_ack_o   = cpu_ack_q;
    cpu_err_o   = cpu_err_q;
    cpu_stall_o = cpu_req_i & ~cpu_ack_q;
    dbg_rdata_o = dbg_rdata_q;
    dbg_ack_o   = dbg_ack_q;
    dbg_err_o   = dbg_err_q;
    wait_cnt_o  = wait_cnt_q;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU MEM stage and a debug/loader requester.
- Sequences each access with a req/ack handshake to the memory and stalls the CPU pipeline while its access is pending.
- Guards against a hung memory with a timeout, and counts CPU wait cycles so stall statistics can be observed.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT, 16, max cycles in a grant state without mem_ack_i before abort; legal range 1..255.
- CNT_W, 16, width of wait_cnt_o.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  CPU access request; held with payload until cpu_ack_o.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  ADDR_W  byte address.
- cpu_wdata_i  in  DATA_W  write data.
- cpu_rdata_o  out  DATA_W  read data; valid when cpu_ack_o, held until next CPU completion.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cpu_err_o  out  1  coincident with cpu_ack_o when the access timed out.
- cpu_stall_o  out  1  pipeline stall = cpu_req_i & ~cpu_ack_o (combinational).
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  same as CPU.
- dbg_rdata_o, dbg_ack_o, dbg_err_o  out  same as CPU.
- mem_req_o  out  1  memory request, held until mem_ack_i.
- mem_we_o  out  1  registered command.
- mem_addr_o  out  ADDR_W  registered command.
- mem_wdata_o  out  DATA_W  registered command.
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion, any latency >= 0 cycles after mem_req_o rises.
- wait_cnt_o  out  CNT_W  saturating count of cycles with cpu_stall_o = 1.

Behaviour:
- Reset (rst_i = 0, asynchronous) forces:
  - state = IDLE; last_grant = DBG.
  - all *_ack_o, *_err_o, mem_req_o = 0.
  - mem_*, rdata outputs = 0; wait_cnt_o = 0; timeout counter = 0.
- States:
  - IDLE: arbitrate.
  - GNT_CPU / GNT_DBG: mem_req_o = 1, command registers drive mem_*.
  - DONE: ack pulse; no arbitration this cycle.
- IDLE transitions:
  - Only one req: grant it.
  - Both req: grant the one not equal to last_grant (round-robin). CPU wins the first tie after reset.
  - On grant edge: latch we/addr/wdata of the winner into the command registers; update last_grant; clear the timeout counter.
- GNT_x on mem_ack_i = 1:
  - Capture mem_rdata_i into x_rdata_o (reads only; writes leave rdata unchanged).
  - Go to DONE with x_ack_o = 1 and mem_req_o = 0 next cycle.
- GNT_x timeout: if the counter reaches TIMEOUT-1 without ack, go to DONE with x_ack_o = 1, x_err_o = 1, rdata unchanged.
- DONE lasts exactly 1 cycle, then IDLE. The requester drops req in the ack cycle, so the stale req is never re-granted.
- Minimum turnaround with zero-wait memory is 3 cycles:
  - req seen in cycle 0.
  - mem_req_o and mem_ack_i in cycle 1.
  - ack_o in cycle 2.
  - IDLE in cycle 3.
- mem_ack_i is ignored in IDLE and DONE (a stale ack after reset or abort has no effect).
- A requester changing its payload while req is pending is illegal; the arbiter uses the value latched at grant.
- wait_cnt_o increments every cycle cpu_stall_o = 1 and saturates at all-ones.
- Reset mid-transaction aborts it silently: no ack is issued and the requester must re-request.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, GNT_CPU, GNT_DBG, DONE) and grant id constants (GRANT_CPU = 0, GRANT_DBG = 1).
- No sub-module: the arbiter, timeout counter and wait counter are small enough to live inline.

Test Plan:
- CPU read 0x0 with mem_rdata_i = 5 and zero-wait memory, requested in cycle 0 -> mem_req_o in cycle 1; cpu_ack_o = 1 and cpu_rdata_o = 5 in cycle 2; wait_cnt_o = 2.
- Simultaneous cpu_req_i and dbg_req_i after reset, twice -> first grant CPU, second grant DBG; mem_addr_o follows each grant.
- DBG write addr 0x8, data 0xDEAD, with mem_ack_i delayed 4 cycles -> mem_req_o high 5 cycles; dbg_ack_o 1 cycle later; dbg_rdata_o unchanged.
- CPU read with mem_ack_i never asserted, TIMEOUT = 16 -> cpu_ack_o = 1 and cpu_err_o = 1 exactly 16 cycles after grant; then IDLE.
- rst_i pulsed low during GNT_CPU -> all outputs 0 immediately; a late mem_ack_i is ignored; no cpu_ack_o.
- cpu_req_i held high for 2^CNT_W+4 cycles (CNT_W = 4, memory never acks, TIMEOUT = 255) -> wait_cnt_o saturates at 15.
